// File: rtl/sram_like_arbiter.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter
//
// Purpose:
//   Shares one sram-like slave port between the CPU instruction-fetch master
//   (inst_*) and the data master (data_*). It sits between the core and the
//   sram-like-to-AXI bridge. One request is granted per cycle, and the grant
//   is held until the slave accepts the address. An in-order FIFO of
//   requester IDs routes every mem_data_ok / mem_rdata back to the master
//   that issued the matching request.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN - when defined, contested unlocked cycles alternate
//                        between the masters. When undefined, data always
//                        beats inst.
//
// Parameters:
//   MAX_OUTSTANDING - accepted-but-not-completed limit. Must be a power of
//                     two and >= 2.
//   CNT_W           - outstanding counter width. Needs 2**CNT_W > MAX_OUTSTANDING.
//
// Ports:
//   clk, reset                     clock, async active-high reset
//   inst_req/wr/size/wstrb/addr/wdata  instruction master request fields
//   inst_addr_ok/data_ok/rdata         instruction master responses
//   data_req/wr/size/wstrb/addr/wdata  data master request fields
//   data_addr_ok/data_ok/rdata         data master responses
//   mem_req/wr/size/wstrb/addr/wdata   slave request fields
//   mem_addr_ok/data_ok/rdata          slave responses
//   busy                           at least one transaction outstanding
//   proto_err                      sticky: slave answered with nothing outstanding
// ---------------------------------------------------------------------------
module sram_like_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        busy,
    output logic        proto_err
);

    localparam int   PTR_W   = $clog2(MAX_OUTSTANDING);
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    // ID FIFO state. One bit per slot is enough because there are only two masters.
    logic [MAX_OUTSTANDING-1:0] r_fifo;
    logic [PTR_W-1:0]           r_head;
    logic [PTR_W-1:0]           r_tail;
    logic [CNT_W-1:0]           r_count;

    // Grant lock state
    logic                       r_lock;
    logic                       r_locked_id;

    logic                       r_proto_err;

`ifdef ARB_ROUND_ROBIN_EN
    // ID that won the most recent accepted request
    logic                       r_last_grant;
`endif

    logic                       w_full;
    logic                       w_winner;
    logic                       w_win_req;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_head_id;

    assign w_full = (r_count == CNT_W'(MAX_OUTSTANDING));

    // Winner select. A held lock overrides every priority rule, so the slave
    // sees stable fields until it accepts them.
    always_comb begin
        w_winner = ID_INST;
        if (r_lock) begin
            w_winner = r_locked_id;
        end
`ifdef ARB_ROUND_ROBIN_EN
        else if (data_req && inst_req) begin
            w_winner = ~r_last_grant;
        end
`endif
        else if (data_req) begin
            w_winner = ID_DATA;
        end else begin
            w_winner = ID_INST;
        end
    end

    // A locked master that drops req ends up with w_win_req = 0. That
    // suppresses mem_req for the cycle, and the lock is released below.
    assign w_win_req = (w_winner == ID_DATA) ? data_req : inst_req;

    // Outputs are gated by reset so nothing leaks while reset is asserted,
    // before any flop has been clocked.
    assign mem_req   = ~reset & ~w_full & w_win_req;
    assign mem_wr    = (w_winner == ID_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (w_winner == ID_DATA) ? data_size  : inst_size;
    assign mem_wstrb = (w_winner == ID_DATA) ? data_wstrb : inst_wstrb;
    assign mem_addr  = (w_winner == ID_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (w_winner == ID_DATA) ? data_wdata : inst_wdata;

    assign w_push = mem_req & mem_addr_ok;
    assign w_pop  = ~reset & mem_data_ok & (r_count != '0);

    assign inst_addr_ok = w_push & (w_winner == ID_INST);
    assign data_addr_ok = w_push & (w_winner == ID_DATA);

    // The oldest outstanding ID owns the current response.
    assign w_head_id    = r_fifo[r_head];
    assign inst_data_ok = w_pop & (w_head_id == ID_INST);
    assign data_data_ok = w_pop & (w_head_id == ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign busy      = (r_count != '0);
    assign proto_err = r_proto_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifo      <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_lock      <= 1'b0;
            r_locked_id <= ID_INST;
            r_proto_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_grant <= ID_DATA;
`endif
        end else begin
            if (w_push) begin
                r_fifo[r_tail] <= w_winner;
                r_tail         <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // A response with nothing outstanding is dropped and flagged.
            // This includes the case where an accept happens in the same cycle,
            // because that response cannot belong to the request just accepted.
            if (mem_data_ok && (r_count == '0)) begin
                r_proto_err <= 1'b1;
            end

            if (r_lock && !w_win_req) begin
                r_lock <= 1'b0;
            end else if (mem_req && !mem_addr_ok) begin
                r_lock      <= 1'b1;
                r_locked_id <= w_winner;
            end else if (w_push) begin
                r_lock <= 1'b0;
            end

`ifdef ARB_ROUND_ROBIN_EN
            if (w_push) begin
                r_last_grant <= w_winner;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [31:0] IADDR = 32'hBFC0_0000;
    localparam logic [31:0] DADDR = 32'h8000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 1;
    logic [1:0]  inst_size = 2'd2, data_size = 2'd2;
    logic [3:0]  inst_wstrb = 4'h0, data_wstrb = 4'hF;
    logic [31:0] inst_addr = IADDR, inst_wdata = 32'h0;
    logic [31:0] data_addr = DADDR, data_wdata = 32'hDEAD_BEEF;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 0, mem_data_ok = 0;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy, proto_err;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_OUTSTANDING(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .busy(busy), .proto_err(proto_err)
    );

    typedef struct {
        logic        ireq, dreq, aok, dok;
        logic [31:0] rdata;
        logic        mreq, win, iaok, daok, idok, ddok, bsy, perr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic ireq, dreq, aok, dok, input logic [31:0] rd,
                                input logic mreq, win, iaok, daok, idok, ddok, bsy, perr);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok; v.rdata = rd;
        v.mreq = mreq; v.win = win; v.iaok = iaok; v.daok = daok;
        v.idok = idok; v.ddok = ddok; v.bsy = bsy; v.perr = perr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_row(input int i, input vec_t v);
        string p;
        p = $sformatf("row%0d", i);
        chk({p, ".mem_req"}, 32'(mem_req), 32'(v.mreq));
        chk({p, ".inst_addr_ok"}, 32'(inst_addr_ok), 32'(v.iaok));
        chk({p, ".data_addr_ok"}, 32'(data_addr_ok), 32'(v.daok));
        chk({p, ".inst_data_ok"}, 32'(inst_data_ok), 32'(v.idok));
        chk({p, ".data_data_ok"}, 32'(data_data_ok), 32'(v.ddok));
        chk({p, ".busy"}, 32'(busy), 32'(v.bsy));
        chk({p, ".proto_err"}, 32'(proto_err), 32'(v.perr));
        if (v.mreq) begin
            chk({p, ".mem_addr"}, mem_addr, v.win ? DADDR : IADDR);
            chk({p, ".mem_wr"}, 32'(mem_wr), v.win ? 32'd1 : 32'd0);
        end
        if (v.dok) begin
            chk({p, ".inst_rdata"}, inst_rdata, v.rdata);
            chk({p, ".data_rdata"}, data_rdata, v.rdata);
        end
    endtask

    initial begin
        logic w [4];
        // Contested winners for four back-to-back requests (last accepted was inst)
        w[0] = 1'b1; w[1] = RR ? 1'b0 : 1'b1; w[2] = 1'b1; w[3] = RR ? 1'b0 : 1'b1;

        // single inst read
        vt.push_back(mk(1,0,1,0,32'h0,        1,0,1,0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,32'h0,        0,0,0,0,0,0,1,0));
        vt.push_back(mk(0,0,0,1,32'h3C1D0000, 0,0,0,0,1,0,1,0));
        // contention: data then inst, responses in that order
        vt.push_back(mk(1,1,1,0,32'h0,        1,1,0,1,0,0,0,0));
        vt.push_back(mk(1,0,1,0,32'h0,        1,0,1,0,0,0,1,0));
        vt.push_back(mk(0,0,0,1,32'h11111111, 0,0,0,0,0,1,1,0));
        vt.push_back(mk(0,0,0,1,32'h22222222, 0,0,0,0,1,0,1,0));
        // grant lock holds inst while data rises
        vt.push_back(mk(1,0,0,0,32'h0,        1,0,0,0,0,0,0,0));
        vt.push_back(mk(1,1,0,0,32'h0,        1,0,0,0,0,0,0,0));
        vt.push_back(mk(1,1,0,0,32'h0,        1,0,0,0,0,0,0,0));
        vt.push_back(mk(1,1,1,0,32'h0,        1,0,1,0,0,0,0,0));
        vt.push_back(mk(0,1,1,0,32'h0,        1,1,0,1,0,0,1,0));
        vt.push_back(mk(0,0,0,1,32'h33333333, 0,0,0,0,1,0,1,0));
        vt.push_back(mk(0,0,0,1,32'h44444444, 0,0,0,0,0,1,1,0));
        // locked master drops req: no transfer, lock released
        vt.push_back(mk(1,0,0,0,32'h0,        1,0,0,0,0,0,0,0));
        vt.push_back(mk(0,1,1,0,32'h0,        0,0,0,0,0,0,0,0));
        vt.push_back(mk(0,1,1,0,32'h0,        1,1,0,1,0,0,0,0));
        vt.push_back(mk(0,0,0,1,32'h55555555, 0,0,0,0,0,1,1,0));
        // FIFO full
        vt.push_back(mk(1,0,1,0,32'h0,        1,0,1,0,0,0,0,0));
        for (int k = 0; k < 3; k++) vt.push_back(mk(1,0,1,0,32'h0, 1,0,1,0,0,0,1,0));
        vt.push_back(mk(1,0,1,0,32'h0,        0,0,0,0,0,0,1,0));
        vt.push_back(mk(1,0,1,1,32'h66666666, 0,0,0,0,1,0,1,0));
        vt.push_back(mk(1,0,1,0,32'h0,        1,0,1,0,0,0,1,0));
        for (int k = 0; k < 4; k++) vt.push_back(mk(0,0,0,1,32'h77777770 + k, 0,0,0,0,1,0,1,0));
        // continuous contention
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(1,1,1,0,32'h0, 1,w[k],~w[k],w[k],0,0,(k != 0),0));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(0,0,0,1,32'hA0A0A0A0 + k, 0,0,0,0,~w[k],w[k],1,0));
        // response with nothing outstanding
        vt.push_back(mk(0,0,0,1,32'h88888888, 0,0,0,0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,32'h0,        0,0,0,0,0,0,0,1));
        vt.push_back(mk(1,0,1,1,32'h99999999, 1,0,1,0,0,0,0,1));
        vt.push_back(mk(0,0,0,0,32'h0,        0,0,0,0,0,0,1,1));

        // reset state with every input pushing to produce output
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        #12;
        chk("rst.mem_req", 32'(mem_req), 32'd0);
        chk("rst.inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("rst.data_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("rst.inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("rst.data_data_ok", 32'(data_data_ok), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.proto_err", 32'(proto_err), 32'd0);
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        @(negedge clk);
        reset = 0;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            inst_req = vt[i].ireq; data_req = vt[i].dreq;
            mem_addr_ok = vt[i].aok; mem_data_ok = vt[i].dok; mem_rdata = vt[i].rdata;
            @(negedge clk);
            chk_row(i, vt[i]);
            @(posedge clk); #1;
        end

        // reset in the middle of a burst: one outstanding, push a second
        data_req = 1; mem_addr_ok = 1; mem_data_ok = 0;
        @(posedge clk); #1;
        data_req = 0; mem_addr_ok = 0;
        @(negedge clk);
        chk("burst.busy", 32'(busy), 32'd1);
        #2;
        reset = 1;
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.proto_err", 32'(proto_err), 32'd0);
        chk("midrst.mem_req", 32'(mem_req), 32'd0);
        chk("midrst.addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        chk("midrst.data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        inst_req = 0; data_req = 0; mem_addr_ok = 0;
        @(negedge clk);
        reset = 0;
        // stale response after reset is dropped
        #1;
        chk("postrst.data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        @(posedge clk); #1;
        mem_data_ok = 0;
        @(negedge clk);
        chk("postrst.proto_err", 32'(proto_err), 32'd1);
        chk("postrst.busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like slave port between the instruction-fetch master (pre-IF/IF) and the data master (EX/MEM) of the CPU.
- Sits between the core and the sram-like-to-AXI bridge.
- Grants one request per cycle and holds the grant until the address is accepted.
- Keeps an in-order FIFO of requester IDs for outstanding transactions, so each mem_data_ok and mem_rdata goes back to the master that issued it.

Parameters:
- MAX_OUTSTANDING, 4: max accepted-but-not-completed transactions; power of two, >= 2.
- CNT_W, 3: outstanding counter width; must satisfy 2^CNT_W > MAX_OUTSTANDING.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- inst_req / inst_wr  in  1 / 1  instruction master request / write
- inst_size / inst_wstrb  in  2 / 4  instruction master size / byte strobes
- inst_addr / inst_wdata  in  32 / 32  instruction master address / write data
- inst_addr_ok / inst_data_ok  out  1 / 1  instruction master handshakes
- inst_rdata  out  32  instruction master read data
- data_req / data_wr / data_size / data_wstrb / data_addr / data_wdata  in  1/1/2/4/32/32  data master request fields
- data_addr_ok / data_data_ok  out  1 / 1  data master handshakes
- data_rdata  out  32  data master read data
- mem_req / mem_wr / mem_size / mem_wstrb / mem_addr / mem_wdata  out  1/1/2/4/32/32  slave request fields
- mem_addr_ok / mem_data_ok  in  1 / 1  slave handshakes
- mem_rdata  in  32  slave read data
- busy  out  1  outstanding count is nonzero
- proto_err  out  1  sticky flag: mem_data_ok arrived with nothing outstanding

Behaviour:
- Reset (asynchronous, active-high): ID FIFO empty, count 0, head and tail pointers 0, grant lock 0, locked_id 0, proto_err 0.
- While reset is asserted, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are all 0.
- Request phase (combinational):
  - full = (count == MAX_OUTSTANDING).
  - If full, mem_req = 0 and both addr_ok = 0.
  - Otherwise the winner is chosen as follows:
    - If lock = 1, the winner is locked_id.
    - Else if data_req = 1, the winner is data (ID 1).
    - Else if inst_req = 1, the winner is inst (ID 0).
  - mem_* fields mux from the winner; mem_req = winner's req.
  - winner_addr_ok = mem_addr_ok & mem_req. The other master's addr_ok is 0.
- Grant lock: the slave must see stable request fields until it accepts them.
  - If mem_req & ~mem_addr_ok, next cycle lock = 1 and locked_id = winner.
  - If mem_addr_ok, lock clears.
  - A locked master that drops req (an exception flush) also clears lock that cycle, and no transfer happens.
- ID FIFO:
  - push = mem_req & mem_addr_ok, writing the winner ID at the tail.
  - pop = mem_data_ok & (count != 0).
  - Push and pop in the same cycle leave count unchanged and advance both pointers. Pointers wrap modulo MAX_OUTSTANDING.
  - A push is impossible when full because mem_req is gated.
- Response routing (combinational, zero latency):
  - inst_data_ok = pop & (head_id == 0); data_data_ok = pop & (head_id == 1).
  - mem_rdata is broadcast to inst_rdata and data_rdata.
- Response with nothing outstanding: mem_data_ok while count == 0 is dropped, with no underflow. proto_err is set and stays set until reset.
- Same-cycle accept and response with count == 0: the response belongs to no accepted transaction. It is dropped and proto_err is set; the push still happens.
- Request-to-accept latency equals the slave's addr_ok latency; the arbiter adds no cycle.
- Both masters may have transactions outstanding at once; completion order is the slave's in-order acceptance order.
- busy = (count != 0).

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both masters request and no lock is held, priority alternates.
  - A 1-bit last_grant register updates on each push.
  - The master that did not win the last push wins.
  - last_grant resets to 1 (data), so inst wins the first contested cycle.
- Undefined: fixed data-over-inst priority as above, and last_grant is not implemented.

Test Plan:
- Single inst read:
  - Stimulus: inst_req = 1, addr 0xBFC00000; mem_addr_ok in the same cycle; mem_data_ok 2 cycles later with rdata 0x3C1D0000.
  - Required: inst_addr_ok and inst_data_ok each pulse once, inst_rdata = 0x3C1D0000, data_data_ok stays 0.
- Contention, fixed priority:
  - Stimulus: inst_req and data_req both 1 with mem_addr_ok = 1.
  - Required: data granted first, inst the next cycle; data_ok pulses return in order data then inst.
- Grant lock:
  - Stimulus: inst_req alone with mem_addr_ok = 0 for 3 cycles; data_req rises in cycle 2.
  - Required: mem_addr stays the inst address until accept, then data is granted.
- FIFO full:
  - Stimulus: 4 accepted reads with no mem_data_ok, then a 5th request.
  - Required: mem_req = 0 and addr_ok = 0. After one mem_data_ok, the 5th request is accepted the same cycle the pop frees a slot, or later.
- Response with nothing outstanding:
  - Stimulus: mem_data_ok with count 0.
  - Required: no data_ok pulse, proto_err = 1. Assert reset mid-burst (2 outstanding): busy = 0 immediately, with no stray data_ok afterwards.
- ARB_ROUND_ROBIN_EN defined:
  - Stimulus: both masters request continuously.
  - Required: grants alternate inst, data, inst, data.
